stream_tag_tracker: RTL and testbench
=====================================

STREAM_TAG_TRACKER -- requirements
Module: stream_tag_tracker

Interface
REQ-001 SHALL have parameters: addr_width=64 (request address bits); data_width=1024 (response data bits); nstrms=64 (stream count); tag=256 (tag count); l2_ncl=256 (L2 lines per stream); max_out=16 (per-stream outstanding limit, 1..tag). Derived: nstrms_width, tag_width, l2_ncl_width, out_width=$clog2(max_out+1).
REQ-002 SHALL have ports:
clk  in  1  clock; all state samples on the rising edge.
reset  in  1  asynchronous, active-low reset.
i_req_v / i_req_r  in / out  1 / 1  request handshake.
i_req_sid  in  nstrms_width  stream id.
i_req_ea  in  addr_width  effective address.
o_req_v / o_req_r  out / in  1 / 1  issued-request handshake.
o_req_ea  out  addr_width  issued address.
o_req_tag  out  tag_width  allocated tag.
i_rsp_v / i_rsp_r  in / out  1 / 1  response handshake.
i_rsp_tag  in  tag_width  returning tag.
i_rsp_data  in  data_width  line data.
o_rsp_v / o_rsp_r  out / in  1 / 1  tagged-response handshake.
o_rsp_data  out  data_width  line data.
o_rsp_sid  out  nstrms_width  stream id recorded for the tag.
o_rsp_ptr  out  l2_ncl_width  line pointer recorded for the tag.
o_out_cnt  out  tag_width+1  total outstanding tags.
o_err  out  1  sticky unknown-tag error.

Function
REQ-003 SHALL hold a free-tag pool: all tags free after reset; the first tag allocations are issued in ascending order 0..tag-1; after that, returned tags are reissued in return order (FIFO, depth tag).
REQ-004 SHALL keep a tag table of tag entries {valid, sid, ptr=ea[l2_ncl_width-1:0]} and nstrms per-stream outstanding counters of out_width bits.
REQ-005 SHALL assert i_req_r only when all hold: the pool is non-empty, cnt[i_req_sid] < max_out, and the request output register is empty or drains this cycle.
REQ-006 On i_req handshake, SHALL in the same edge: pop a tag, write its table entry with valid=1, increment cnt[sid], and load {ea, tag} into the output register; o_req_v SHALL rise the next cycle (latency 1).
REQ-007 o_req_v/ea/tag SHALL stay stable until o_req_r; the block SHALL sustain one request per cycle.
REQ-008 i_rsp SHALL pass through a one-entry response register; i_rsp_r=1 when that register is empty or drains this cycle.
REQ-009 The table SHALL be read with the registered tag; o_rsp_v SHALL rise one cycle after the i_rsp handshake, with o_rsp_sid/ptr from the table and o_rsp_data from the register; all held stable until o_rsp_r.
REQ-010 On o_rsp handshake, SHALL push the tag to the pool, clear its valid bit, and decrement cnt[sid].
REQ-011 A response whose tag has valid=0 SHALL be consumed without o_rsp_v; o_err SHALL set and stay 1 until reset; the pool and counters SHALL be unchanged.
REQ-012 A same-cycle allocate and return SHALL both complete; the returned tag SHALL NOT be issued in that cycle; if both hit the same stream, its counter SHALL be unchanged; o_out_cnt SHALL be unchanged.
REQ-013 A table write and read to the same tag in one cycle SHALL be impossible by construction (valid gating); no bypass is required.
REQ-014 o_out_cnt SHALL equal allocations minus returns; it SHALL never exceed tag and never underflow.

Reset
REQ-015 While reset=0, SHALL drive o_req_v=0, o_rsp_v=0, i_req_r=0, i_rsp_r=0, o_out_cnt=0, o_err=0; all valid bits and counters SHALL be 0 and the pool full; table sid/ptr contents are don't-care.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight requests and responses; the first allocation after release SHALL be tag 0.

Verification
REQ-017 After reset, 3 requests (sid 5; ea 0x100, 0x140, 0x180) with o_req_r=1 -> tags 0, 1, 2, each 1 cycle after accept; o_out_cnt=3.
REQ-018 Response tag 1, data D -> o_rsp_v one cycle later with sid=5, ptr=0x40, data D; o_out_cnt=2; the next allocation after tags 0..255 are exhausted is tag 1.
REQ-019 max_out=16, 17 requests on sid 3 with no responses -> i_req_r=0 on the 17th while sid 4 is still accepted; one sid-3 response -> the 17th is accepted.
REQ-020 tag=4: 4 requests, then a 5th held off; a response and a new request in the same cycle -> both complete, o_out_cnt stays 4.
REQ-021 Response with never-issued tag 7 -> i_rsp_r handshake, no o_rsp_v, o_err=1 sticky, counters unchanged.
REQ-022 reset=0 while 2 tags are outstanding and o_rsp_r=0 -> all outputs 0; after release, the first request gets tag 0.

Source files
------------

// File: rtl/stream_tag_tracker.sv
// stream_tag_tracker: allocates tags to stream requests, tracks per-stream outstanding counts,
// and maps returning tagged responses back to their stream id and line pointer.
module stream_tag_tracker #(
  parameter int addr_width = 64,
  parameter int data_width = 1024,
  parameter int nstrms = 64,
  parameter int tag = 256,
  parameter int l2_ncl = 256,
  parameter int max_out = 16,
  localparam int nstrms_width = $clog2(nstrms),
  localparam int tag_width = $clog2(tag),
  localparam int l2_ncl_width = $clog2(l2_ncl),
  localparam int out_width = $clog2(max_out + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  input  logic [nstrms_width-1:0] i_req_sid,
  input  logic [addr_width-1:0]   i_req_ea,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [addr_width-1:0]   o_req_ea,
  output logic [tag_width-1:0]    o_req_tag,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  input  logic [tag_width-1:0]    i_rsp_tag,
  input  logic [data_width-1:0]   i_rsp_data,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [data_width-1:0]   o_rsp_data,
  output logic [nstrms_width-1:0] o_rsp_sid,
  output logic [l2_ncl_width-1:0] o_rsp_ptr,
  output logic [tag_width:0]      o_out_cnt,
  output logic                    o_err
);
  logic [tag_width:0] fresh, fifo_cnt, out_cnt;
  logic [tag_width-1:0] head, tail, rtag, rsp_tag, pop_tag;
  logic [tag_width-1:0] fifo [tag];
  logic [nstrms_width-1:0] sid_tab [tag];
  logic [l2_ncl_width-1:0] ptr_tab [tag];
  logic [out_width-1:0] cnt [nstrms];
  logic [tag-1:0] valid;
  logic [addr_width-1:0] ea;
  logic [data_width-1:0] rsp_data;
  logic [nstrms_width-1:0] rsid;
  logic req_v, rsp_v, err, fresh_done, pool_ne, hit, ret, alloc, same, rsp_drain, rsp_take;

  function automatic logic [tag_width-1:0] nxt(input logic [tag_width-1:0] p);
    return p == tag_width'(tag - 1) ? '0 : p + 1'b1;
  endfunction

  // Never-used tags come from a counter first; returned tags queue behind them in the FIFO,
  // which behaves exactly like a pool preloaded with 0..tag-1.
  assign fresh_done = fresh == (tag_width+1)'(tag);
  assign pool_ne = !fresh_done || fifo_cnt != '0;
  assign pop_tag = fresh_done ? fifo[head] : fresh[tag_width-1:0];
  assign hit = valid[rsp_tag];
  assign rsid = sid_tab[rsp_tag];
  assign ret = rsp_v && hit && o_rsp_r;
  assign rsp_drain = rsp_v && (!hit || o_rsp_r);
  assign i_rsp_r = reset && (!rsp_v || rsp_drain);
  assign i_req_r = reset && pool_ne && cnt[i_req_sid] < out_width'(max_out) && (!req_v || o_req_r);
  assign alloc = i_req_v && i_req_r;
  assign rsp_take = i_rsp_v && i_rsp_r;
  assign same = alloc && ret && rsid == i_req_sid;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      req_v <= 1'b0;
      rsp_v <= 1'b0;
      fresh <= '0;
      fifo_cnt <= '0;
      head <= '0;
      tail <= '0;
      valid <= '0;
      out_cnt <= '0;
      err <= 1'b0;
      for (int i = 0; i < nstrms; i++) cnt[i] <= '0;
    end else begin
      req_v <= alloc || (req_v && !o_req_r);
      rsp_v <= rsp_take || (rsp_v && !rsp_drain);
      if (alloc && !fresh_done) fresh <= fresh + 1'b1;
      if (alloc && fresh_done) head <= nxt(head);
      if (ret) tail <= nxt(tail);
      fifo_cnt <= fifo_cnt + (tag_width+1)'(ret) - (tag_width+1)'(alloc && fresh_done);
      out_cnt <= out_cnt + (tag_width+1)'(alloc) - (tag_width+1)'(ret);
      if (alloc) valid[pop_tag] <= 1'b1;
      if (ret) valid[rsp_tag] <= 1'b0;
      if (alloc && !same) cnt[i_req_sid] <= cnt[i_req_sid] + 1'b1;
      if (ret && !same) cnt[rsid] <= cnt[rsid] - 1'b1;
      if (rsp_v && !hit) err <= 1'b1;
    end

  always_ff @(posedge clk) begin
    if (alloc) begin
      ea <= i_req_ea;
      rtag <= pop_tag;
      sid_tab[pop_tag] <= i_req_sid;
      ptr_tab[pop_tag] <= i_req_ea[l2_ncl_width-1:0];
    end
    if (rsp_take) begin
      rsp_tag <= i_rsp_tag;
      rsp_data <= i_rsp_data;
    end
    if (ret) fifo[tail] <= rsp_tag;
  end

  assign o_req_v = req_v;
  assign o_req_ea = ea;
  assign o_req_tag = rtag;
  assign o_rsp_v = rsp_v && hit;
  assign o_rsp_data = rsp_data;
  assign o_rsp_sid = rsid;
  assign o_rsp_ptr = ptr_tab[rsp_tag];
  assign o_out_cnt = out_cnt;
  assign o_err = err;
endmodule

// File: tb/tb_stream_tag_tracker.sv
// tb_stream_tag_tracker: directed scenarios for stream_tag_tracker with 32 tags, 8 streams, max_out 16.
module tb_stream_tag_tracker;
  localparam int AW = 16, DW = 32, NS = 8, TG = 32, L2 = 256, MO = 16;
  logic clk = 0, reset = 0;
  logic i_req_v = 0, i_req_r, o_req_v, o_req_r = 0;
  logic [2:0] i_req_sid = 0, o_rsp_sid;
  logic [AW-1:0] i_req_ea = 0, o_req_ea;
  logic [4:0] o_req_tag, i_rsp_tag = 0;
  logic i_rsp_v = 0, i_rsp_r, o_rsp_v, o_rsp_r = 0, o_err;
  logic [DW-1:0] i_rsp_data = 0, o_rsp_data;
  logic [7:0] o_rsp_ptr;
  logic [5:0] o_out_cnt;
  int total = 0, bad = 0;

  stream_tag_tracker #(.addr_width(AW), .data_width(DW), .nstrms(NS), .tag(TG), .l2_ncl(L2), .max_out(MO)) dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid), .i_req_ea(i_req_ea),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_ea(o_req_ea), .o_req_tag(o_req_tag),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_tag(i_rsp_tag), .i_rsp_data(i_rsp_data),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_data(o_rsp_data), .o_rsp_sid(o_rsp_sid),
    .o_rsp_ptr(o_rsp_ptr), .o_out_cnt(o_out_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 0;
    i_req_v = 0;
    i_rsp_v = 0;
    tick;
    tick;
    reset = 1;
  endtask

  task automatic test_reset;
    reset = 0;
    i_req_v = 1;
    i_rsp_v = 1;
    #1;
    total++;
    if ({o_req_v, o_rsp_v, i_req_r, i_rsp_r, o_out_cnt, o_err} !== 11'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 000", {o_req_v, o_rsp_v, i_req_r, i_rsp_r, o_out_cnt, o_err});
    end
    i_req_v = 0;
    i_rsp_v = 0;
    tick;
    reset = 1;
  endtask

  task automatic test_alloc;
    do_reset;
    o_req_r = 1;
    o_rsp_r = 1;
    for (int k = 0; k < 3; k++) begin
      i_req_v = 1;
      i_req_sid = 5;
      i_req_ea = 16'h100 + 16'(k * 'h40);
      #1;
      total++;
      if (i_req_r !== 1'b1) begin bad++; $display("FAIL alloc_ready%0d: got %b want 1", k, i_req_r); end
      tick;
      total++;
      if ({o_req_v, o_req_tag, o_req_ea} !== {1'b1, 5'(k), 16'h100 + 16'(k * 'h40)}) begin
        bad++;
        $display("FAIL alloc_out%0d: got v=%b tag=%0d ea=%h want v=1 tag=%0d", k, o_req_v, o_req_tag, o_req_ea, k);
      end
    end
    i_req_v = 0;
    total++;
    if (o_out_cnt !== 6'd3) begin bad++; $display("FAIL alloc_cnt: got %0d want 3", o_out_cnt); end
    tick;
    total++;
    if (o_req_v !== 1'b0) begin bad++; $display("FAIL alloc_drain: got %b want 0", o_req_v); end
  endtask

  task automatic test_response;
    i_rsp_v = 1;
    i_rsp_tag = 1;
    i_rsp_data = 32'hdead_beef;
    #1;
    total++;
    if (i_rsp_r !== 1'b1) begin bad++; $display("FAIL rsp_ready: got %b want 1", i_rsp_r); end
    tick;
    i_rsp_v = 0;
    #1;
    total++;
    if ({o_rsp_v, o_rsp_sid, o_rsp_ptr, o_rsp_data} !== {1'b1, 3'd5, 8'h40, 32'hdead_beef}) begin
      bad++;
      $display("FAIL rsp_out: got v=%b sid=%0d ptr=%h data=%h want v=1 sid=5 ptr=40 data=deadbeef", o_rsp_v, o_rsp_sid, o_rsp_ptr, o_rsp_data);
    end
    tick;
    total++;
    if ({o_rsp_v, o_out_cnt} !== {1'b0, 6'd2}) begin bad++; $display("FAIL rsp_return: got v=%b cnt=%0d want v=0 cnt=2", o_rsp_v, o_out_cnt); end
    for (int k = 3; k < 32; k++) begin
      i_req_v = 1;
      i_req_sid = 3'(k % 8);
      i_req_ea = 16'(k * 64);
      tick;
      total++;
      if (o_req_tag !== 5'(k)) begin bad++; $display("FAIL exhaust_tag%0d: got %0d want %0d", k, o_req_tag, k); end
    end
    tick;
    total++;
    if ({o_req_v, o_req_tag} !== {1'b1, 5'd1}) begin bad++; $display("FAIL reissue_tag: got v=%b tag=%0d want v=1 tag=1", o_req_v, o_req_tag); end
    total++;
    if (o_out_cnt !== 6'd32) begin bad++; $display("FAIL full_cnt: got %0d want 32", o_out_cnt); end
    #1;
    total++;
    if (i_req_r !== 1'b0) begin bad++; $display("FAIL empty_pool_ready: got %b want 0", i_req_r); end
    i_req_v = 0;
  endtask

  task automatic test_max_out;
    do_reset;
    o_req_r = 1;
    o_rsp_r = 1;
    for (int k = 0; k < 16; k++) begin
      i_req_v = 1;
      i_req_sid = 3;
      i_req_ea = 16'(k * 'h40);
      tick;
      total++;
      if (o_req_tag !== 5'(k)) begin bad++; $display("FAIL max_tag%0d: got %0d want %0d", k, o_req_tag, k); end
    end
    #1;
    total++;
    if (i_req_r !== 1'b0) begin bad++; $display("FAIL max_block17: got %b want 0", i_req_r); end
    i_req_sid = 4;
    #1;
    total++;
    if (i_req_r !== 1'b1) begin bad++; $display("FAIL max_other_sid: got %b want 1", i_req_r); end
    tick;
    total++;
    if (o_req_tag !== 5'd16) begin bad++; $display("FAIL max_other_tag: got %0d want 16", o_req_tag); end
    i_req_sid = 3;
    i_rsp_v = 1;
    i_rsp_tag = 0;
    i_rsp_data = 32'h33;
    #1;
    total++;
    if (i_req_r !== 1'b0) begin bad++; $display("FAIL max_still_block: got %b want 0", i_req_r); end
    tick;
    i_rsp_v = 0;
    #1;
    total++;
    if ({o_rsp_v, o_rsp_sid, i_req_r} !== {1'b1, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL max_rsp: got v=%b sid=%0d rdy=%b want v=1 sid=3 rdy=0", o_rsp_v, o_rsp_sid, i_req_r);
    end
    tick;
    total++;
    if (i_req_r !== 1'b1) begin bad++; $display("FAIL max_release: got %b want 1", i_req_r); end
    tick;
    total++;
    if ({o_req_v, o_req_tag} !== {1'b1, 5'd17}) begin bad++; $display("FAIL max_17th_tag: got v=%b tag=%0d want v=1 tag=17", o_req_v, o_req_tag); end
    i_req_v = 0;
  endtask

  task automatic test_back_to_back;
    do_reset;
    o_req_r = 1;
    o_rsp_r = 1;
    for (int k = 0; k < 32; k++) begin
      i_req_v = 1;
      i_req_sid = k < 16 ? 3'd0 : 3'd1;
      i_req_ea = 16'(k);
      tick;
    end
    total++;
    if ({o_req_tag, o_out_cnt} !== {5'd31, 6'd32}) begin bad++; $display("FAIL b2b_fill: got tag=%0d cnt=%0d want tag=31 cnt=32", o_req_tag, o_out_cnt); end
    i_req_sid = 2;
    #1;
    total++;
    if (i_req_r !== 1'b0) begin bad++; $display("FAIL b2b_held: got %b want 0", i_req_r); end
    i_req_v = 0;
    i_rsp_v = 1;
    i_rsp_tag = 5;
    tick;
    i_rsp_tag = 6;
    tick;
    i_rsp_v = 0;
    i_req_v = 1;
    i_req_sid = 0;
    #1;
    total++;
    if ({i_req_r, o_rsp_v, o_out_cnt} !== {1'b1, 1'b1, 6'd31}) begin
      bad++;
      $display("FAIL b2b_pre: got rdy=%b rspv=%b cnt=%0d want rdy=1 rspv=1 cnt=31", i_req_r, o_rsp_v, o_out_cnt);
    end
    tick;
    total++;
    if ({o_req_v, o_req_tag, o_out_cnt, o_rsp_v} !== {1'b1, 5'd5, 6'd31, 1'b0}) begin
      bad++;
      $display("FAIL b2b_same_cycle: got v=%b tag=%0d cnt=%0d rspv=%b want v=1 tag=5 cnt=31 rspv=0", o_req_v, o_req_tag, o_out_cnt, o_rsp_v);
    end
    i_req_v = 0;
    i_rsp_v = 1;
    i_rsp_tag = 20;
    tick;
    i_rsp_v = 0;
    tick;
    i_req_v = 1;
    i_req_sid = 0;
    #1;
    total++;
    if (i_req_r !== 1'b1) begin bad++; $display("FAIL b2b_sid0_ready: got %b want 1", i_req_r); end
    tick;
    total++;
    if (o_req_tag !== 5'd6) begin bad++; $display("FAIL b2b_fifo_order: got %0d want 6", o_req_tag); end
    #1;
    total++;
    if (i_req_r !== 1'b0) begin bad++; $display("FAIL b2b_sid0_limit: got %b want 0", i_req_r); end
    i_req_sid = 1;
    #1;
    tick;
    total++;
    if ({o_req_tag, o_out_cnt} !== {5'd20, 6'd32}) begin bad++; $display("FAIL b2b_sid1: got tag=%0d cnt=%0d want tag=20 cnt=32", o_req_tag, o_out_cnt); end
    i_req_v = 0;
  endtask

  task automatic test_unknown_tag;
    do_reset;
    o_req_r = 1;
    o_rsp_r = 1;
    i_req_v = 1;
    i_req_sid = 2;
    i_req_ea = 16'h80;
    tick;
    i_req_v = 0;
    i_rsp_v = 1;
    i_rsp_tag = 7;
    i_rsp_data = 32'h77;
    #1;
    total++;
    if (i_rsp_r !== 1'b1) begin bad++; $display("FAIL unk_ready: got %b want 1", i_rsp_r); end
    tick;
    i_rsp_v = 0;
    #1;
    total++;
    if ({o_rsp_v, o_err} !== 2'b00) begin bad++; $display("FAIL unk_no_valid: got v=%b err=%b want v=0 err=0", o_rsp_v, o_err); end
    tick;
    total++;
    if ({o_err, o_out_cnt, i_rsp_r, o_rsp_v} !== {1'b1, 6'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL unk_err: got err=%b cnt=%0d rdy=%b v=%b want err=1 cnt=1 rdy=1 v=0", o_err, o_out_cnt, i_rsp_r, o_rsp_v);
    end
    tick;
    tick;
    tick;
    total++;
    if (o_err !== 1'b1) begin bad++; $display("FAIL unk_sticky: got %b want 1", o_err); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    o_req_r = 1;
    o_rsp_r = 0;
    i_req_v = 1;
    i_req_sid = 1;
    i_req_ea = 16'h10;
    tick;
    i_req_ea = 16'h20;
    tick;
    i_req_v = 0;
    o_req_r = 0;
    tick;
    total++;
    if ({o_req_v, o_req_tag, o_req_ea} !== {1'b1, 5'd1, 16'h20}) begin
      bad++;
      $display("FAIL mid_hold: got v=%b tag=%0d ea=%h want v=1 tag=1 ea=0020", o_req_v, o_req_tag, o_req_ea);
    end
    i_rsp_v = 1;
    i_rsp_tag = 0;
    tick;
    i_rsp_v = 0;
    tick;
    total++;
    if ({o_rsp_v, o_rsp_ptr, o_out_cnt} !== {1'b1, 8'h10, 6'd2}) begin
      bad++;
      $display("FAIL mid_rsp_hold: got v=%b ptr=%h cnt=%0d want v=1 ptr=10 cnt=2", o_rsp_v, o_rsp_ptr, o_out_cnt);
    end
    reset = 0;
    #1;
    total++;
    if ({o_req_v, o_rsp_v, i_req_r, i_rsp_r, o_out_cnt, o_err} !== 11'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h want 000", {o_req_v, o_rsp_v, i_req_r, i_rsp_r, o_out_cnt, o_err});
    end
    tick;
    reset = 1;
    o_req_r = 1;
    i_req_v = 1;
    i_req_sid = 6;
    i_req_ea = 16'h55;
    #1;
    tick;
    i_req_v = 0;
    total++;
    if ({o_req_v, o_req_tag, o_out_cnt} !== {1'b1, 5'd0, 6'd1}) begin
      bad++;
      $display("FAIL mid_first_tag: got v=%b tag=%0d cnt=%0d want v=1 tag=0 cnt=1", o_req_v, o_req_tag, o_out_cnt);
    end
  endtask

  initial begin
    tick;
    test_reset;
    test_alloc;
    test_response;
    test_max_out;
    test_back_to_back;
    test_unknown_tag;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
